// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: I-cache port, D-cache port and SDRAM burst port.
// The slave modport is the arbiter's view; master is the view of the
// environment that drives the caches and the SDRAM controller.
interface mem_arbiter_if;
  // I-cache side
  logic         i_req;
  logic [31:0]  i_addr;
  logic         i_done;
  logic         i_err;
  logic [127:0] i_rdata;
  // D-cache side
  logic         d_req;
  logic         d_we;
  logic [31:0]  d_addr;
  logic [127:0] d_wdata;
  logic         d_done;
  logic         d_err;
  logic [127:0] d_rdata;
  // SDRAM controller side
  logic         sdram_req;
  logic         sdram_we;
  logic [23:0]  sdram_addr;
  logic         sdram_ack;
  logic [15:0]  sdram_wdata;
  logic         sdram_wnext;
  logic [15:0]  sdram_rdata;
  logic         sdram_rvalid;
  logic         sdram_done;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
           sdram_ack, sdram_wnext, sdram_rdata, sdram_rvalid, sdram_done,
    output i_done, i_err, i_rdata, d_done, d_err, d_rdata,
           sdram_req, sdram_we, sdram_addr, sdram_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
           sdram_ack, sdram_wnext, sdram_rdata, sdram_rvalid, sdram_done,
    input  i_done, i_err, i_rdata, d_done, d_err, d_rdata,
           sdram_req, sdram_we, sdram_addr, sdram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SDRAM burst port between the I-cache refill path and
// the D-cache refill/write-back path. One 128-bit line per transaction, moved
// as 8 x 16-bit words, MSB word first. Round-robin on ties, out-of-range
// addresses answered with an error and no SDRAM access.
// Optional: define MEM_ARB_PERF_EN to add grant and wait-cycle counters.
module mem_arbiter #(
  parameter int          BURST_LEN = 8,
  parameter logic [31:0] MEM_TOP   = 32'h01ff_ffff
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]  perf_i_grants,
  output logic [31:0]  perf_d_grants,
  output logic [31:0]  perf_wait_cycles
`endif
);

  localparam logic [3:0] LAST_CNT = 4'(BURST_LEN);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WR, S_RD, S_RESP, S_ERR} state_e;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_e;

  state_e           state_q, state_d;
  gnt_e             grant_q, grant_d;
  gnt_e             last_q, last_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [7:0][15:0] line_q, line_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic [127:0]     i_rdata_q, i_rdata_d;
  logic [127:0]     d_rdata_q, d_rdata_d;

  gnt_e             pick;
  logic [31:0]      pick_addr;
  logic [3:0]       cnt_inc;
  logic             seen_now;
  logic [2:0]       widx;
  logic             fin;
  logic             busy;

  // Word k of the line sits at packed index 7-k, i.e. the bitwise inverse of k.
  assign widx = ~cnt_q[2:0];

  // Next-state, latched request fields and line buffer updates.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    line_d    = line_q;
    cnt_d     = cnt_q;
    seen_d    = seen_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    cnt_inc   = cnt_q;
    seen_now  = seen_q | bus.sdram_done;

    if (bus.i_req && bus.d_req) pick = (last_q == GNT_I) ? GNT_D : GNT_I;
    else if (bus.d_req)         pick = GNT_D;
    else                        pick = GNT_I;
    pick_addr = (pick == GNT_D) ? bus.d_addr : bus.i_addr;

    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        seen_d = 1'b0;
        if (bus.i_req || bus.d_req) begin
          grant_d = pick;
          we_d    = (pick == GNT_D) && bus.d_we;
          addr_d  = pick_addr;
          line_d  = bus.d_wdata;
          state_d = (pick_addr > MEM_TOP) ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        if (bus.sdram_ack) state_d = we_q ? S_WR : S_RD;
      end
      S_WR: begin
        if (bus.sdram_wnext && cnt_q != LAST_CNT) cnt_inc = cnt_q + 4'd1;
        cnt_d  = cnt_inc;
        seen_d = seen_now;
        if (cnt_inc == LAST_CNT && seen_now) state_d = S_RESP;
      end
      S_RD: begin
        if (bus.sdram_rvalid && cnt_q != LAST_CNT) begin
          line_d[widx] = bus.sdram_rdata;
          cnt_inc      = cnt_q + 4'd1;
        end
        cnt_d  = cnt_inc;
        seen_d = seen_now;
        // A burst that ends before the line is full is a protocol fault.
        if (seen_now) state_d = (cnt_inc == LAST_CNT) ? S_RESP : S_ERR;
      end
      S_RESP: begin
        last_d  = grant_q;
        cnt_d   = '0;
        state_d = S_IDLE;
        if (grant_q == GNT_D) d_rdata_d = line_q;
        else                  i_rdata_d = line_q;
      end
      S_ERR: begin
        last_d  = grant_q;
        cnt_d   = '0;
        state_d = S_IDLE;
        if (grant_q == GNT_D) d_rdata_d = '0;
        else                  i_rdata_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset aborts any burst.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= GNT_I;
      last_q    <= GNT_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      line_q    <= '0;
      cnt_q     <= '0;
      seen_q    <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      line_q    <= line_d;
      cnt_q     <= cnt_d;
      seen_q    <= seen_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign fin  = (state_q == S_RESP) || (state_q == S_ERR);
  assign busy = (state_q == S_REQ) || (state_q == S_WR) || (state_q == S_RD);

  // Responses are decoded from the state; rdata shows the new line during the
  // done cycle and the registered copy holds it afterwards.
  assign bus.i_done  = fin && (grant_q == GNT_I);
  assign bus.i_err   = (state_q == S_ERR) && (grant_q == GNT_I);
  assign bus.i_rdata = bus.i_done ? ((state_q == S_RESP) ? line_q : '0) : i_rdata_q;
  assign bus.d_done  = fin && (grant_q == GNT_D);
  assign bus.d_err   = (state_q == S_ERR) && (grant_q == GNT_D);
  assign bus.d_rdata = bus.d_done ? ((state_q == S_RESP) ? line_q : '0) : d_rdata_q;

  // Line-aligned SDRAM word address; low nibble of the byte address dropped.
  assign bus.sdram_req   = (state_q == S_REQ);
  assign bus.sdram_we    = busy && we_q;
  assign bus.sdram_addr  = busy ? {addr_q[24:4], 3'b000} : '0;
  assign bus.sdram_wdata = ((state_q == S_WR) && cnt_q != LAST_CNT) ? line_q[widx] : '0;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] pi_q, pi_d, pd_q, pd_d, pw_q, pw_d;

  // Grant counts on each IDLE grant; wait count while the other side is held off.
  always_comb begin
    pi_d = pi_q;
    pd_d = pd_q;
    pw_d = pw_q;
    if (state_q == S_IDLE) begin
      if (bus.i_req || bus.d_req) begin
        if (pick == GNT_D) pd_d = pd_q + 32'd1;
        else               pi_d = pi_q + 32'd1;
      end
      if (bus.i_req && bus.d_req) pw_d = pw_q + 32'd1;
    end else if ((grant_q == GNT_I) ? bus.d_req : bus.i_req) begin
      pw_d = pw_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pi_q <= '0;
      pd_q <= '0;
      pw_q <= '0;
    end else begin
      pi_q <= pi_d;
      pd_q <= pd_d;
      pw_q <= pw_d;
    end
  end

  assign perf_i_grants    = pi_q;
  assign perf_d_grants    = pd_q;
  assign perf_wait_cycles = pw_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Plays both caches and the SDRAM
// controller; a small model (round-robin winner, address arithmetic, line
// packing by shifts, held rdata per side) supplies every expected value.
module tb_mem_arbiter;
  localparam logic [31:0] MEM_TOP = 32'h01ff_ffff;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if bus();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  bit           ip, dp, dwe, last_d, d_known;
  logic [31:0]  ia, da;
  logic [127:0] dwd, exp_i_rdata, exp_d_rdata;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] map_addr(input logic [31:0] a);
    return 24'(((a % 32'h0200_0000) / 32'd16) * 32'd8);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_i_done"},      128'(bus.i_done),      '0);
    check({tag, "_i_err"},       128'(bus.i_err),       '0);
    check({tag, "_i_rdata"},     bus.i_rdata,           '0);
    check({tag, "_d_done"},      128'(bus.d_done),      '0);
    check({tag, "_d_err"},       128'(bus.d_err),       '0);
    check({tag, "_d_rdata"},     bus.d_rdata,           '0);
    check({tag, "_sdram_req"},   128'(bus.sdram_req),   '0);
    check({tag, "_sdram_we"},    128'(bus.sdram_we),    '0);
    check({tag, "_sdram_addr"},  128'(bus.sdram_addr),  '0);
    check({tag, "_sdram_wdata"}, 128'(bus.sdram_wdata), '0);
  endtask

  task automatic post_i(input logic [31:0] a);
    ip = 1'b1; ia = a;
    bus.i_req = 1'b1; bus.i_addr = a;
  endtask

  task automatic post_d(input bit we, input logic [31:0] a, input logic [127:0] wd);
    dp = 1'b1; dwe = we; da = a; dwd = wd;
    bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
  endtask

  // Serve one transaction, starting at a negedge with the arbiter idle.
  // n_words: read beats before sdram_done; done_with_last: sdram_done on the
  // final beat; extra_beat: one surplus wnext/rvalid that must be ignored;
  // seq_words: read words are 1..8 instead of random.
  task automatic serve(input int n_words, input bit done_with_last,
                       input bit extra_beat, input bit seq_words);
    bit           g_d, we, err, chk_rd;
    logic [31:0]  a;
    logic [15:0]  w;
    logic [127:0] line, exp_rd;
    g_d  = dp && (!ip || !last_d);
    a    = g_d ? da : ia;
    we   = g_d && dwe;
    line = '0;
    tick();
    if (a > MEM_TOP) begin
      check("range_no_sdram_req", 128'(bus.sdram_req), '0);
      err    = 1'b1;
      exp_rd = '0;
    end else begin
      check("sdram_req_rise", 128'(bus.sdram_req), 128'(1'b1));
      check("sdram_addr", 128'(bus.sdram_addr), 128'(map_addr(a)));
      check("sdram_we", 128'(bus.sdram_we), 128'(we));
      repeat ($urandom_range(0, 2)) begin
        tick();
        check("sdram_req_hold", 128'(bus.sdram_req), 128'(1'b1));
      end
      bus.sdram_ack = 1'b1; tick(); bus.sdram_ack = 1'b0;
      check("sdram_req_drop", 128'(bus.sdram_req), '0);
      if (we) begin
        for (int k = 0; k < 8; k++) begin
          repeat ($urandom_range(0, 1)) tick();
          check("sdram_wdata", 128'(bus.sdram_wdata), 128'(16'(dwd >> (16 * (7 - k)))));
          bus.sdram_wnext = 1'b1;
          bus.sdram_done  = (k == 7) && done_with_last;
          tick();
          bus.sdram_wnext = 1'b0;
          bus.sdram_done  = 1'b0;
        end
        if (!done_with_last) begin
          if (extra_beat) begin bus.sdram_wnext = 1'b1; tick(); bus.sdram_wnext = 1'b0; end
          repeat ($urandom_range(0, 2)) tick();
          bus.sdram_done = 1'b1; tick(); bus.sdram_done = 1'b0;
        end
        err    = 1'b0;
        exp_rd = '0;
      end else begin
        for (int k = 0; k < n_words; k++) begin
          repeat ($urandom_range(0, 1)) tick();
          w    = seq_words ? 16'(k + 1) : 16'($urandom);
          line = {line[111:0], w};
          bus.sdram_rvalid = 1'b1;
          bus.sdram_rdata  = w;
          bus.sdram_done   = (k == n_words - 1) && done_with_last;
          tick();
          bus.sdram_rvalid = 1'b0;
          bus.sdram_done   = 1'b0;
        end
        if (!done_with_last) begin
          if (extra_beat && n_words == 8) begin
            bus.sdram_rvalid = 1'b1; bus.sdram_rdata = 16'hdead; tick(); bus.sdram_rvalid = 1'b0;
          end
          repeat ($urandom_range(0, 2)) tick();
          bus.sdram_done = 1'b1; tick(); bus.sdram_done = 1'b0;
        end
        err    = (n_words < 8);
        exp_rd = err ? '0 : line;
      end
    end
    // Response cycle: write-back success leaves rdata unspecified.
    chk_rd = !we || err;
    if (g_d) begin
      check("d_done", 128'(bus.d_done), 128'(1'b1));
      check("d_err", 128'(bus.d_err), 128'(err));
      if (chk_rd) check("d_rdata", bus.d_rdata, exp_rd);
      check("i_done_quiet", 128'(bus.i_done), '0);
      check("i_rdata_hold", bus.i_rdata, exp_i_rdata);
      d_known     = chk_rd;
      exp_d_rdata = exp_rd;
      dp = 1'b0; bus.d_req = 1'b0;
    end else begin
      check("i_done", 128'(bus.i_done), 128'(1'b1));
      check("i_err", 128'(bus.i_err), 128'(err));
      check("i_rdata", bus.i_rdata, exp_rd);
      check("d_done_quiet", 128'(bus.d_done), '0);
      if (d_known) check("d_rdata_hold", bus.d_rdata, exp_d_rdata);
      exp_i_rdata = exp_rd;
      ip = 1'b0; bus.i_req = 1'b0;
    end
    last_d = g_d;
    tick();
    check("done_one_cycle", 128'(bus.i_done | bus.d_done), '0);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 32'h0200_0000 + ($urandom & 32'h00ff_fff0);
    return $urandom & MEM_TOP;
  endfunction

  initial begin
    int mode;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.sdram_ack = 1'b0; bus.sdram_wnext = 1'b0; bus.sdram_rdata = '0;
    bus.sdram_rvalid = 1'b0; bus.sdram_done = 1'b0;
    ip = 1'b0; dp = 1'b0; dwe = 1'b0; last_d = 1'b0; d_known = 1'b1;
    ia = '0; da = '0; dwd = '0; exp_i_rdata = '0; exp_d_rdata = '0;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_all_zero("reset");

    // First tie after reset goes to D, then I (I read returns words 1..8)
    post_i(32'h0000_1230);
    post_d(1'b0, 32'h0000_4000, '0);
    serve(8, 1'b0, 1'b0, 1'b0);
    serve(8, 1'b1, 1'b0, 1'b1);
    check("i_line_words_1_to_8", bus.i_rdata, 128'h0001_0002_0003_0004_0005_0006_0007_0008);

    // Repeated ties keep alternating
    for (int n = 0; n < 2; n++) begin
      post_i(32'h0000_0100 + 32'(n) * 32'h40);
      post_d(1'b0, 32'h0001_0000 + 32'(n) * 32'h40, '0);
      serve(8, 1'b0, 1'b0, 1'b0);
      serve(8, 1'b0, 1'b0, 1'b0);
    end

    // D write-back with a surplus 9th wnext
    post_d(1'b1, 32'h0100_0040, 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_7777_8888);
    serve(8, 1'b0, 1'b1, 1'b0);

    // Range error: no SDRAM access, error done in the next cycle
    post_d(1'b0, 32'h0200_0000, '0);
    serve(8, 1'b0, 1'b0, 1'b0);

    // Short reads, then a normal read is accepted
    post_i(32'h0000_2000);
    serve(5, 1'b0, 1'b0, 1'b0);
    post_i(32'h0000_2010);
    serve(3, 1'b1, 1'b0, 1'b0);
    post_i(32'h0000_2020);
    serve(8, 1'b0, 1'b1, 1'b0);

    // Reset during a write burst after 3 words
    post_d(1'b1, 32'h0000_8000, {$urandom, $urandom, $urandom, $urandom});
    tick();
    check("abort_sdram_req", 128'(bus.sdram_req), 128'(1'b1));
    bus.sdram_ack = 1'b1; tick(); bus.sdram_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("abort_wdata", 128'(bus.sdram_wdata), 128'(16'(dwd >> (16 * (7 - k)))));
      bus.sdram_wnext = 1'b1; tick(); bus.sdram_wnext = 1'b0;
    end
    rst = 1'b1; bus.d_req = 1'b0; dp = 1'b0;
    tick();
    check_all_zero("abort");
    rst = 1'b0;
    last_d = 1'b0; exp_i_rdata = '0; exp_d_rdata = '0; d_known = 1'b1;
    post_i(32'h0000_3450);
    serve(8, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      mode = int'($urandom_range(0, 2));
      if (mode != 1) post_i(rand_addr());
      if (mode != 0) post_d(bit'($urandom_range(0, 1)), rand_addr(),
                            {$urandom, $urandom, $urandom, $urandom});
      serve(($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 8,
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0);
      if (mode == 2)
        serve(($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 8,
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
